ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameters: none.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_in  in  1  asynchronous, active-low reset.
REQ-005 WB_in  in  2  writeback control from ID/EX, passed through.
REQ-006 M_in  in  2  memory control from ID/EX, passed through.
REQ-007 EX_in  in  4  [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc.
REQ-008 Reg1Data_in, Reg2Data_in, Sext_in  in  32 each  operands and sign-extended immediate.
REQ-009 Regt_in, Regd_in, Regs_in  in  5 each  register numbers (Regs_in is unused and SHALL be ignored).
REQ-010 flush_in  in  1  synchronous bubble request.
REQ-011 stall_out  out  1  upstream SHALL hold ID/EX inputs stable while this is high.
REQ-012 WB_out, M_out  out  2 each; ALUResult_out  out  32; WriteData_out  out  32; Zero_out  out  1; WriteReg_out  out  5. Together these form the registered EX/MEM bundle.

Function
REQ-013 Operand B SHALL be Sext_in when ALUSrc=1, else Reg2Data_in.
REQ-014 ALUOp handling SHALL be:
- 00: add.
- 01: subtract.
- 10: decode funct=Sext_in[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 1/0), 0x18 mult (REQ-027); any other funct gives result 0.
- 11: result 0.
REQ-015 Add and subtract SHALL wrap modulo 2^32, with no overflow trap.
REQ-016 Zero SHALL be 1 when the 32-bit result equals 0.
REQ-017 WriteReg SHALL be Regd_in when RegDst=1, else Regt_in.
REQ-018 WriteData SHALL be Reg2Data_in, regardless of ALUSrc.
REQ-019 Non-stalled, non-flushed cycles: all EX/MEM outputs SHALL load on the rising edge, giving 1-cycle latency.
REQ-020 A bubble SHALL load WB_out=0, M_out=0, ALUResult_out=0, WriteData_out=0, Zero_out=0, WriteReg_out=0.
REQ-021 flush_in=1 SHALL load a bubble on that edge.
REQ-022 flush_in SHALL take priority over the FSM and over stall (REQ-029).
REQ-023 Whenever stall_out=1 at an edge, EX/MEM SHALL load a bubble.

Reset
REQ-024 reset_in=0 SHALL immediately clear all EX/MEM outputs to 0, the FSM to IDLE, and the multiplier count, multiplicand and product registers to 0.
REQ-025 After reset, stall_out SHALL be 0.
REQ-026 Reset asserted mid-multiply SHALL abort the multiply, and no result SHALL be written afterwards.

Configuration
REQ-027 Macro EX_MULT_EN, when defined: funct 0x18 with ALUOp=10 SHALL run an iterative unsigned shift-add multiply. The FSM SHALL be:
- IDLE: a mult is present at the inputs, so stall_out=1 (combinational) and the FSM moves to BUSY with count=0.
- BUSY: one partial-product step per cycle with stall_out=1; after the step at count=31 the FSM moves to DONE.
- DONE: stall_out=0; EX/MEM loads the low 32 product bits as ALUResult, with Zero, WB/M and WriteReg per REQ-016/017; the FSM returns to IDLE.
REQ-028 With EX_MULT_EN defined, stall_out SHALL be high for exactly 33 consecutive cycles per mult, and the result SHALL appear on the 34th edge.
REQ-029 With EX_MULT_EN defined, flush_in=1 in BUSY or DONE SHALL abort the multiply to IDLE and load a bubble.
REQ-030 Without EX_MULT_EN: funct 0x18 SHALL give result 0 like any unknown funct; no FSM or multiplier logic SHALL exist; stall_out SHALL be tied to 0.

Verification
REQ-031 R-type add: EX=1100, funct 0x20, Reg1=0xFFFFFFFF, Reg2=1, Regd=5 -> next edge ALUResult=0, Zero=1, WriteReg=5, WB/M passed through.
REQ-032 lw: EX=0001, Reg1=0x100, Sext=0xFFFFFFFC, Regt=9 -> ALUResult=0xFC, WriteReg=9, WriteData=Reg2.
REQ-033 slt: funct 0x2A, Reg1=0x80000000, Reg2=1 -> ALUResult=1.
REQ-034 EX_MULT_EN, mult 7x6 -> stall_out high 33 cycles; EX/MEM WB/M=0 throughout; 34th edge ALUResult=42.
REQ-035 EX_MULT_EN, flush_in at BUSY count 10 -> bubble loaded, stall_out=0 next cycle, FSM IDLE; separately, reset_in=0 at count 20 -> outputs 0 immediately, no later result.
REQ-036 No EX_MULT_EN, mult funct -> stall_out stays 0; next edge ALUResult=0, Zero=1.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX stage ALU plus EX/MEM pipeline register.
// Define EX_MULT_EN to add a 33-stall iterative shift-add multiply (funct 0x18).
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [1:0]  WB_in,
  input  logic [1:0]  M_in,
  input  logic [3:0]  EX_in,
  input  logic [31:0] Reg1Data_in,
  input  logic [31:0] Reg2Data_in,
  input  logic [31:0] Sext_in,
  input  logic [4:0]  Regt_in,
  input  logic [4:0]  Regd_in,
  input  logic [4:0]  Regs_in,
  input  logic        flush_in,
  output logic        stall_out,
  output logic [1:0]  WB_out,
  output logic [1:0]  M_out,
  output logic [31:0] ALUResult_out,
  output logic [31:0] WriteData_out,
  output logic        Zero_out,
  output logic [4:0]  WriteReg_out
);

  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] result;
  logic [5:0]  funct;
  logic        bubble;
  logic        unused_regs;

  assign unused_regs = ^Regs_in;
  assign op_b  = EX_in[0] ? Sext_in : Reg2Data_in;
  assign funct = Sext_in[5:0];

  always_comb begin
    alu_res = '0;
    unique case (EX_in[2:1])
      2'b00: alu_res = Reg1Data_in + op_b;
      2'b01: alu_res = Reg1Data_in - op_b;
      2'b10: begin
        unique case (funct)
          6'h20:   alu_res = Reg1Data_in + op_b;
          6'h22:   alu_res = Reg1Data_in - op_b;
          6'h24:   alu_res = Reg1Data_in & op_b;
          6'h25:   alu_res = Reg1Data_in | op_b;
          6'h2A:   alu_res = {31'b0,
                     $signed(Reg1Data_in) < $signed(op_b)};
          default: alu_res = '0;
        endcase
      end
      2'b11: alu_res = '0;
    endcase
  end

`ifdef EX_MULT_EN
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mult_state_t;

  mult_state_t state;
  logic [4:0]  count;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] prod;
  logic        is_mult;

  assign is_mult   = (EX_in[2:1] == 2'b10) && (funct == 6'h18);
  assign stall_out = (state == BUSY) ||
                     ((state == IDLE) && is_mult);
  assign result    = (state == DONE) ? prod : alu_res;
  assign bubble    = flush_in | stall_out;

  // Only the low 32 product bits are kept, so wrap is intended.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (flush_in) begin
      state <= IDLE;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_mult) begin
            state  <= BUSY;
            count  <= '0;
            mcand  <= Reg1Data_in;
            mplier <= op_b;
            prod   <= '0;
          end
        end
        BUSY: begin
          prod   <= prod + (mplier[0] ? mcand : 32'd0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'd31) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign stall_out = 1'b0;
  assign result    = alu_res;
  assign bubble    = flush_in;
`endif

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in || bubble) begin
      WB_out        <= '0;
      M_out         <= '0;
      ALUResult_out <= '0;
      WriteData_out <= '0;
      Zero_out      <= 1'b0;
      WriteReg_out  <= '0;
    end else begin
      WB_out        <= WB_in;
      M_out         <= M_in;
      ALUResult_out <= result;
      WriteData_out <= Reg2Data_in;
      Zero_out      <= (result == 32'd0);
      WriteReg_out  <= EX_in[3] ? Regd_in : Regt_in;
    end
  end

endmodule
